// File: rtl/muldiv_sched.sv
// muldiv_sched: sequences the multiply/divide units and the HI/LO register
// writes for MULT/DIV instructions. It launches the selected unit, waits for
// its completion (or divide-by-zero / watchdog expiry), then commits or
// aborts. It also stalls MFHI/MFLO reads while an operation is in flight.
module muldiv_sched #(
    parameter int TIMEOUT = 40,  // cycles a unit may run from its launch cycle; 2 <= TIMEOUT < 2**CNT_W
    parameter int CNT_W   = 6    // watchdog counter width
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic start_i,
    input  logic op_i,          // 0 = MULT, 1 = DIV (sampled with start_i)
    input  logic hilo_rd_i,
    input  logic mult_done_i,
    input  logic div_done_i,
    input  logic div0_i,
    output logic mult_start_o,
    output logic div_start_o,
    output logic hi_sel_o,      // 0 = divider, 1 = multiplier
    output logic lo_sel_o,      // 0 = divider, 1 = multiplier
    output logic hi_we_o,
    output logic lo_we_o,
    output logic busy_o,
    output logic stall_o,
    output logic done_o,
    output logic div0_exc_o,
    output logic timeout_o,
    output logic start_err_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MULT_RUN = 3'd1,
        S_DIV_RUN  = 3'd2,
        S_WRITE    = 3'd3,
        S_DIV0     = 3'd4,
        S_TMO      = 3'd5
    } state_t;

    // Counter value seen in the last cycle a unit is allowed to run.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             launch_q, launch_d;       // first cycle of a run state
    logic             hi_sel_q, hi_sel_d;
    logic             lo_sel_q, lo_sel_d;
    logic             start_err_q, start_err_d;

    logic             accept;                   // start taken from IDLE
    logic             expired;                  // watchdog reached its last cycle

    assign accept  = (state_q == S_IDLE) && start_i;
    assign expired = (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: launch from IDLE, resolve the run states, then return to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = op_i ? S_DIV_RUN : S_MULT_RUN;
                end
            end
            S_MULT_RUN: begin
                // Completion beats watchdog expiry in the same cycle.
                if (mult_done_i) begin
                    state_d = S_WRITE;
                end else if (expired) begin
                    state_d = S_TMO;
                end
            end
            S_DIV_RUN: begin
                // Divide-by-zero beats completion, which beats expiry.
                if (div0_i) begin
                    state_d = S_DIV0;
                end else if (div_done_i) begin
                    state_d = S_WRITE;
                end else if (expired) begin
                    state_d = S_TMO;
                end
            end
            S_WRITE, S_DIV0, S_TMO: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Next values for the watchdog counter, launch flag, mux selects and start error.
    always_comb begin
        cnt_d       = cnt_q;
        launch_d    = accept;
        hi_sel_d    = hi_sel_q;
        lo_sel_d    = lo_sel_q;
        // A start that arrives while an operation is in flight is dropped and flagged.
        start_err_d = start_i && (state_q != S_IDLE);
        if (accept) begin
            cnt_d    = '0;
            hi_sel_d = ~op_i;
            lo_sel_d = ~op_i;
        end else if ((state_q == S_MULT_RUN) || (state_q == S_DIV_RUN)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers; reset returns selects to the divider side.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q       <= '0;
            launch_q    <= 1'b0;
            hi_sel_q    <= 1'b0;
            lo_sel_q    <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            launch_q    <= launch_d;
            hi_sel_q    <= hi_sel_d;
            lo_sel_q    <= lo_sel_d;
            start_err_q <= start_err_d;
        end
    end

    // Output decode: everything but busy/stall comes from registers only.
    always_comb begin
        mult_start_o = launch_q && (state_q == S_MULT_RUN);
        div_start_o  = launch_q && (state_q == S_DIV_RUN);
        hi_sel_o     = hi_sel_q;
        lo_sel_o     = lo_sel_q;
        hi_we_o      = (state_q == S_WRITE);
        lo_we_o      = (state_q == S_WRITE);
        done_o       = (state_q == S_WRITE);
        div0_exc_o   = (state_q == S_DIV0);
        timeout_o    = (state_q == S_TMO);
        start_err_o  = start_err_q;
        busy_o       = (state_q != S_IDLE);
        // HI/LO only update at the end of WRITE, so reads stall through it too.
        stall_o      = hilo_rd_i && (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// Testbench for muldiv_sched: a vector table, hand-written multi-cycle
// scenarios and a randomized run checked against a cycle-age reference model.
module tb_muldiv_sched;

    localparam int TO = 40;

    // Bit positions inside the packed output vector.
    localparam int B_MS = 11, B_DS = 10, B_HS = 9, B_LS = 8, B_HW = 7, B_LW = 6;
    localparam int B_BUSY = 5, B_STALL = 4, B_DONE = 3, B_D0E = 2, B_TO = 1, B_SE = 0;

    logic clk = 1'b0;
    logic srst, start, op, hilo_rd, mult_done, div_done, div0;
    logic mult_start, div_start, hi_sel, lo_sel, hi_we, lo_we;
    logic busy, stall, done, div0_exc, timeout, start_err;

    int checks = 0;
    int errors = 0;

    logic [11:0] obs [0:63];

    always #5 clk = ~clk;

    muldiv_sched #(.TIMEOUT(TO), .CNT_W(6)) dut (
        .clock_i      (clk),
        .reset_i      (srst),
        .start_i      (start),
        .op_i         (op),
        .hilo_rd_i    (hilo_rd),
        .mult_done_i  (mult_done),
        .div_done_i   (div_done),
        .div0_i       (div0),
        .mult_start_o (mult_start),
        .div_start_o  (div_start),
        .hi_sel_o     (hi_sel),
        .lo_sel_o     (lo_sel),
        .hi_we_o      (hi_we),
        .lo_we_o      (lo_we),
        .busy_o       (busy),
        .stall_o      (stall),
        .done_o       (done),
        .div0_exc_o   (div0_exc),
        .timeout_o    (timeout),
        .start_err_o  (start_err)
    );

    function automatic logic [11:0] pack_out();
        return {mult_start, div_start, hi_sel, lo_sel, hi_we, lo_we,
                busy, stall, done, div0_exc, timeout, start_err};
    endfunction

    task automatic chk_vec(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        srst = 1'b0; start = 1'b0; op = 1'b0; hilo_rd = 1'b0;
        mult_done = 1'b0; div_done = 1'b0; div0 = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        srst = 1'b1;
        tick();
        tick();
        srst = 1'b0;
        #1;
        chk_vec("reset_state", pack_out(), 12'b0);
        tick();
    endtask

    // Count cycles in [lo,hi] where a given output bit was high.
    function automatic int cnt_bit(input int b, input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) begin
            if (obs[c][b]) n++;
        end
        return n;
    endfunction

    // Start at cycle 0, then pulse each event at its cycle (-1 = never) while recording outputs.
    task automatic run_seq(input int n, input logic op_v, input int md_c, input int dd_c,
                           input int d0_c, input int rst_c, input int st2_c, input logic rd_v);
        for (int c = 0; c < n; c++) begin
            start     = (c == 0) || (c == st2_c);
            op        = op_v;
            mult_done = (c == md_c);
            div_done  = (c == dd_c);
            div0      = (c == d0_c);
            srst      = (c == rst_c);
            hilo_rd   = rd_v;
            #1;
            obs[c] = pack_out();
            tick();
        end
        clear_inputs();
    endtask

    typedef struct {
        logic        start;
        logic        op;
        logic        rd;
        logic        md;
        logic        dd;
        logic        d0;
        logic [11:0] exp;
    } vec_t;

    // Reference model: plain record of the operation in flight.
    bit m_run, m_op, m_err, m_sel;
    int m_age;   // cycles since launch; 1 in the launch-pulse cycle
    int m_term;  // terminal cycle kind: 0 none, 1 write, 2 div0, 3 timeout

    function automatic logic [11:0] model_out(input logic rd);
        logic b;
        b = m_run || (m_term != 0);
        return {m_run && !m_op && m_age == 1, m_run && m_op && m_age == 1,
                m_sel, m_sel, m_term == 1, m_term == 1, b, rd && b,
                m_term == 1, m_term == 2, m_term == 3, m_err};
    endfunction

    task automatic model_step();
        bit b, nerr;
        if (srst) begin
            m_run = 0; m_op = 0; m_err = 0; m_sel = 0; m_age = 0; m_term = 0;
        end else begin
            b = m_run || (m_term != 0);
            nerr = start && b;
            if (m_run) begin
                if (m_op && div0) m_term = 2;
                else if (m_op ? div_done : mult_done) m_term = 1;
                else if (m_age == TO) m_term = 3;
                if (m_term != 0) begin
                    m_run = 0;
                    $display("rand txn op=%0d age=%0d end=%0d", m_op, m_age, m_term);
                end else begin
                    m_age++;
                end
            end else if (m_term != 0) begin
                m_term = 0;
            end else if (start) begin
                m_run = 1; m_op = op; m_age = 1; m_sel = ~op;
            end
            m_err = nerr;
        end
    endtask

    initial begin
        vec_t vecs [14];
        vecs[0]  = '{1, 0, 1, 0, 0, 0, 12'b0000_0000_0000};
        vecs[1]  = '{0, 0, 1, 0, 0, 0, 12'b1011_0011_0000};
        vecs[2]  = '{0, 0, 0, 1, 0, 0, 12'b0011_0010_0000};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 12'b0011_1110_1000};
        vecs[4]  = '{1, 1, 0, 0, 0, 0, 12'b0011_0000_0000};
        vecs[5]  = '{0, 0, 0, 1, 1, 1, 12'b0100_0010_0000};
        vecs[6]  = '{1, 0, 0, 0, 0, 0, 12'b0000_0010_0100};
        vecs[7]  = '{0, 0, 0, 1, 1, 1, 12'b0000_0000_0001};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 12'b0000_0000_0000};
        vecs[9]  = '{1, 0, 0, 0, 0, 0, 12'b0000_0000_0000};
        vecs[10] = '{0, 0, 0, 0, 1, 1, 12'b1011_0010_0000};
        vecs[11] = '{0, 0, 0, 1, 0, 0, 12'b0011_0010_0000};
        vecs[12] = '{0, 0, 1, 0, 0, 0, 12'b0011_1111_1000};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 12'b0011_0000_0000};

        clear_inputs();
        do_reset();

        // Vector table: inputs of a cycle and the outputs expected in that same cycle.
        for (int i = 0; i < 14; i++) begin
            start = vecs[i].start; op = vecs[i].op; hilo_rd = vecs[i].rd;
            mult_done = vecs[i].md; div_done = vecs[i].dd; div0 = vecs[i].d0;
            #1;
            chk_vec($sformatf("vec%0d", i), pack_out(), vecs[i].exp);
            $display("vec %0d applied", i);
            tick();
        end
        clear_inputs();

        // MULT completing at 33 with hilo_rd held throughout.
        do_reset();
        run_seq(40, 1'b0, 33, -1, -1, -1, -1, 1'b1);
        chk_int("mult_start_c1", obs[1][B_MS], 1);
        chk_int("mult_start_cnt", cnt_bit(B_MS, 0, 39), 1);
        chk_int("mult_hi_sel", obs[2][B_HS], 1);
        chk_int("mult_lo_sel", obs[2][B_LS], 1);
        chk_int("mult_hi_we_c34", obs[34][B_HW], 1);
        chk_int("mult_lo_we_c34", obs[34][B_LW], 1);
        chk_int("mult_done_c34", obs[34][B_DONE], 1);
        chk_int("mult_we_cnt", cnt_bit(B_HW, 0, 39), 1);
        chk_int("mult_busy_c34", obs[34][B_BUSY], 1);
        chk_int("mult_busy_c35", obs[35][B_BUSY], 0);
        chk_int("stall_idle_c0", obs[0][B_STALL], 0);
        chk_int("stall_cnt_1_34", cnt_bit(B_STALL, 1, 34), 34);
        chk_int("stall_c35", obs[35][B_STALL], 0);
        $display("scenario mult done");

        // DIV with divide-by-zero at 3.
        do_reset();
        run_seq(8, 1'b1, -1, -1, 3, -1, -1, 1'b0);
        chk_int("div0_div_start_c1", obs[1][B_DS], 1);
        chk_int("div0_exc_c4", obs[4][B_D0E], 1);
        chk_int("div0_exc_cnt", cnt_bit(B_D0E, 0, 7), 1);
        chk_int("div0_we_cnt", cnt_bit(B_HW, 0, 7) + cnt_bit(B_LW, 0, 7), 0);
        chk_int("div0_busy_c4", obs[4][B_BUSY], 1);
        chk_int("div0_busy_c5", obs[5][B_BUSY], 0);
        $display("scenario div0 done");

        // DIV with no completion: watchdog.
        do_reset();
        run_seq(45, 1'b1, -1, -1, -1, -1, -1, 1'b0);
        chk_int("tmo_c41", obs[41][B_TO], 1);
        chk_int("tmo_cnt", cnt_bit(B_TO, 0, 44), 1);
        chk_int("tmo_we_cnt", cnt_bit(B_HW, 0, 44), 0);
        chk_int("tmo_busy_c41", obs[41][B_BUSY], 1);
        chk_int("tmo_busy_c42", obs[42][B_BUSY], 0);
        $display("scenario watchdog done");

        // DIV completing on the expiry cycle: completion wins.
        do_reset();
        run_seq(45, 1'b1, -1, 40, -1, -1, -1, 1'b0);
        chk_int("edge_we_c41", obs[41][B_HW], 1);
        chk_int("edge_tmo_cnt", cnt_bit(B_TO, 0, 44), 0);
        chk_int("edge_busy_c42", obs[42][B_BUSY], 0);
        $display("scenario expiry-edge done");

        // Start while MULT is running, then a stray mult_done in IDLE.
        do_reset();
        run_seq(14, 1'b0, 10, -1, -1, -1, 5, 1'b0);
        chk_int("berr_c6", obs[6][B_SE], 1);
        chk_int("berr_cnt", cnt_bit(B_SE, 0, 13), 1);
        chk_int("berr_we_c11", obs[11][B_HW], 1);
        chk_int("berr_done_c11", obs[11][B_DONE], 1);
        chk_int("berr_mult_start_cnt", cnt_bit(B_MS, 0, 13), 1);
        mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        #1;
        chk_int("stray_we", hi_we, 0);
        chk_int("stray_busy", busy, 0);
        tick();
        $display("scenario busy-start done");

        // Reset in cycle 10 of a DIV, div_done arriving in cycle 12.
        do_reset();
        run_seq(20, 1'b1, -1, 12, -1, 10, -1, 1'b0);
        chk_int("rst_div_start_c1", obs[1][B_DS], 1);
        chk_vec("rst_c11_outputs", obs[11], 12'b0);
        chk_int("rst_busy_after", cnt_bit(B_BUSY, 11, 19), 0);
        chk_int("rst_we_cnt", cnt_bit(B_HW, 0, 19), 0);
        $display("scenario mid-op reset done");

        // Randomized run against the reference model.
        do_reset();
        m_run = 0; m_op = 0; m_err = 0; m_sel = 0; m_age = 0; m_term = 0;
        for (int i = 0; i < 6000; i++) begin
            srst      = ($urandom_range(0, 299) == 0);
            start     = ($urandom_range(0, 9) == 0);
            op        = 1'($urandom_range(0, 1));
            hilo_rd   = 1'($urandom_range(0, 1));
            mult_done = ($urandom_range(0, 24) == 0);
            div_done  = ($urandom_range(0, 24) == 0);
            div0      = ($urandom_range(0, 79) == 0);
            #1;
            chk_vec($sformatf("rand%0d", i), pack_out(), model_out(hilo_rd));
            tick();
            model_step();
        end
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Sequencer that owns the multiply and divide units and the HI/LO registers in the multicycle datapath. The main control FSM hands it a single start pulse per MULT/DIV instruction. It then:
- launches the matching unit;
- waits for that unit's completion handshake;
- steers and enables the HI/LO writes;
- reports divide-by-zero and watchdog timeouts;
- stalls MFHI/MFLO while a result is still pending.

## Interface
- TIMEOUT, 40, cycles a unit may run (counted from its launch cycle) before a timeout is declared; must be ≥ 2 and < 2^CNT_W
- CNT_W, 6, watchdog counter width
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request from main control
- op  in  1  operation sampled with start: 0 = MULT, 1 = DIV
- hilo_rd  in  1  main control is executing MFHI/MFLO this cycle
- mult_done  in  1  multiplier completion pulse
- div_done  in  1  divider completion pulse
- div0  in  1  divider divide-by-zero flag
- mult_start  out  1  multiplier launch pulse
- div_start  out  1  divider launch pulse
- hi_sel  out  1  HI mux select: 0 = divider, 1 = multiplier
- lo_sel  out  1  LO mux select: 0 = divider, 1 = multiplier
- hi_we  out  1  HI register write enable
- lo_we  out  1  LO register write enable
- busy  out  1  operation in flight
- stall  out  1  hold main control
- done  out  1  result committed to HI/LO
- div0_exc  out  1  divide-by-zero exception pulse to main control
- timeout  out  1  watchdog expiry pulse
- start_err  out  1  start arrived while busy

## Operation
- States: IDLE, MULT_RUN, DIV_RUN, WRITE, DIV0, TMO.
- IDLE + start:
  - op=0 → MULT_RUN; op=1 → DIV_RUN.
  - Counter cleared to 0.
  - hi_sel and lo_sel both loaded with ~op.
- mult_start is 1 only in the first cycle of MULT_RUN; div_start likewise for DIV_RUN.
- Counter increments every cycle in MULT_RUN and DIV_RUN.
- MULT_RUN exits:
  - mult_done → WRITE.
  - Otherwise, counter == TIMEOUT-1 → TMO.
- DIV_RUN exits, in priority order:
  - div0 → DIV0;
  - div_done → WRITE;
  - counter == TIMEOUT-1 → TMO.
- WRITE: hi_we=lo_we=1, done=1, one cycle, then IDLE.
- DIV0: div0_exc=1, one cycle, no HI/LO write, then IDLE.
- TMO: timeout=1, one cycle, no HI/LO write, then IDLE.
- busy = (state != IDLE); combinational from state.
- stall = hilo_rd & busy; combinational. This covers WRITE, since HI/LO update only at the end of that cycle.
- start while busy:
  - Request is dropped; state unaffected.
  - start_err=1 the following cycle.
- Done pulses in the wrong state are ignored: mult_done/div_done in IDLE, mult_done during DIV_RUN, div_done during MULT_RUN. div0 outside DIV_RUN is also ignored.
- Simultaneous events:
  - Done and counter expiry in the same cycle: done wins.
  - div0 and div_done in the same cycle: div0 wins.
- hi_sel/lo_sel hold their last value outside an operation.

## Timing
- Reset:
  - state = IDLE, counter = 0, hi_sel = lo_sel = 0.
  - All other outputs 0, including stall (busy = 0).
  - Reset takes effect on the next rising edge.
- Reset mid-operation: the next cycle is IDLE and no write enable, exception or done is emitted. The arithmetic units share the same reset.
- All outputs except busy and stall are registered/state-decoded, with no combinational path from inputs.
- Latency for start sampled at edge 0:
  - launch pulse in cycle 1;
  - completion sampled at edge k → hi_we/lo_we/done in cycle k+1;
  - IDLE (busy=0) in cycle k+2;
  - a new start is accepted when sampled in cycle k+2.
- Minimum MULT/DIV turnaround: completion in cycle 1 gives 3 cycles start-to-idle.
- Timeout: with no completion, TMO occupies cycle TIMEOUT+1 and IDLE follows at cycle TIMEOUT+2.

## Test plan
- **MULT:** start, op=0 at cycle 0; mult_done at cycle 33 → mult_start=1 in cycle 1 only; hi_sel=lo_sel=1; hi_we=lo_we=done=1 in cycle 34; busy=0 in cycle 35.
- **DIV by zero:** start, op=1; div0 at cycle 3 → div_start in cycle 1; div0_exc=1 in cycle 4; hi_we/lo_we never asserted; IDLE in cycle 5.
- **Watchdog:** TIMEOUT=40, DIV with no div_done → timeout=1 in cycle 41, no write, busy=0 in cycle 42. In a separate run, div_done at the expiry cycle (40) → WRITE in cycle 41, timeout stays 0.
- **Interlock:** hilo_rd held during a MULT → stall=1 from cycle 1 through the WRITE cycle, 0 the cycle after. hilo_rd in IDLE → stall=0.
- **Busy start:** start during MULT_RUN → start_err=1 next cycle; the original mult completes normally. A stray mult_done in IDLE produces no write.
- **Reset:** reset asserted in cycle 10 of a DIV → IDLE in cycle 11, all outputs 0. A div_done pulse arriving in cycle 12 is ignored.
